retire_commit: RTL and testbench

- In-order retirement stage at the ROB head; it is the producer side of the retire/free-list and architectural-state interface consumed by rename.
- Takes up to MACHINE_WIDTH completed head entries per cycle and commits them to the architectural RAT.
- Returns each committed instruction's previous physical register to the free list over a valid/ready handshake.
- Drives the one-cycle recovery pulse (recov_arch_st) on a mispredicted branch and stops retirement permanently on halt.

---
 rtl/retire_commit.sv | 125 ++++++++++++
 tb/tb_retire_commit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_commit.sv
`default_nettype none
// ============================================================================
// Module   : retire_commit
// Brief    : In-order retirement at the ROB head. Commits up to MACHINE_WIDTH
//            completed instructions per cycle into the architectural RAT,
//            returns each previous physical register to the free list over a
//            valid/ready handshake, pulses recovery on a retired mispredict
//            and stops retirement for good on a retired halt.
// Revision : 1.0 - initial release
// ============================================================================
module retire_commit #(
    parameter int MACHINE_WIDTH = 2,
    parameter int ARF_DEPTH     = 32,
    parameter int ARF_WIDTH     = 5,
    parameter int PRF_WIDTH     = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [MACHINE_WIDTH-1:0]               rob_head_valid,
    input  logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0] rob_head_dest_arn,
    input  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] rob_head_dest_prn,
    input  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] rob_head_dest_prn_prev,
    input  logic [MACHINE_WIDTH-1:0]               rob_head_has_dest,
    input  logic [MACHINE_WIDTH-1:0]               rob_head_mispredict,
    input  logic [MACHINE_WIDTH-1:0]               rob_head_halt,
    output logic [MACHINE_WIDTH-1:0]               rob_retire,
    output logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] retire_prn_prev,
    output logic [MACHINE_WIDTH-1:0]               retire_prn_prev_valid,
    input  logic [MACHINE_WIDTH-1:0]               retire_prn_prev_ready,
    output logic [ARF_DEPTH-1:0][PRF_WIDTH-1:0]    arch_rat,
    output logic                                   recov_arch_st,
    output logic                                   halted,
    output logic [31:0]                            retire_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_RECOVER = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    state_t                   r_state;
    logic [MACHINE_WIDTH-1:0] w_en;
    logic [31:0]              w_retire_pop;
    logic                     w_any_mispredict;
    logic                     w_any_halt;

    // The freed register is always the head entry's old mapping; only the
    // valid qualifier decides whether it is actually offered.
    generate
        for (genvar gi = 0; gi < MACHINE_WIDTH; gi++) begin : g_prev
            assign retire_prn_prev[gi] = rob_head_dest_prn_prev[gi];
        end
    endgenerate

    // Slot enable chain: a slot may retire only if every older slot retires
    // and no older slot is a flushing/halting instruction.
    always_comb begin : comb_enable
        logic w_ok;
        w_ok                  = (r_state == S_RUN) && !rst;
        w_en                  = '0;
        rob_retire            = '0;
        retire_prn_prev_valid = '0;
        w_retire_pop          = '0;
        w_any_mispredict      = 1'b0;
        w_any_halt            = 1'b0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            w_en[i]                  = w_ok & rob_head_valid[i];
            retire_prn_prev_valid[i] = w_en[i] & rob_head_has_dest[i];
            rob_retire[i]            = w_en[i] &
                                       (~rob_head_has_dest[i] | retire_prn_prev_ready[i]);
            w_retire_pop             = w_retire_pop + {31'd0, rob_retire[i]};
            w_any_mispredict         = w_any_mispredict |
                                       (rob_retire[i] & rob_head_mispredict[i]);
            w_any_halt               = w_any_halt | (rob_retire[i] & rob_head_halt[i]);
            w_ok                     = w_ok & rob_retire[i] &
                                       ~rob_head_mispredict[i] & ~rob_head_halt[i];
        end
    end

    // Architectural state, retire counter and the RUN/RECOVER/HALT machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            recov_arch_st <= 1'b0;
            halted        <= 1'b0;
            retire_cnt    <= 32'd0;
            for (int k = 0; k < ARF_DEPTH; k++) begin
                arch_rat[k] <= PRF_WIDTH'(k);
            end
        end else begin
            recov_arch_st <= 1'b0;
            case (r_state)
                S_RUN: begin
                    // Ascending order so the youngest writer of an arn wins.
                    for (int i = 0; i < MACHINE_WIDTH; i++) begin
                        if (rob_retire[i] && rob_head_has_dest[i] &&
                            (rob_head_dest_arn[i] != '0)) begin
                            arch_rat[rob_head_dest_arn[i]] <= rob_head_dest_prn[i];
                        end
                    end
                    retire_cnt <= retire_cnt + w_retire_pop;
                    if (w_any_halt) begin
                        r_state <= S_HALT;
                        halted  <= 1'b1;
                    end else if (w_any_mispredict) begin
                        r_state       <= S_RECOVER;
                        recov_arch_st <= 1'b1;
                    end
                end
                S_RECOVER: begin
                    r_state <= S_RUN;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_retire_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_commit
// Brief    : Directed self-checking bench for retire_commit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_commit;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       rob_head_valid;
    logic [1:0][4:0]  rob_head_dest_arn;
    logic [1:0][5:0]  rob_head_dest_prn;
    logic [1:0][5:0]  rob_head_dest_prn_prev;
    logic [1:0]       rob_head_has_dest;
    logic [1:0]       rob_head_mispredict;
    logic [1:0]       rob_head_halt;
    logic [1:0]       rob_retire;
    logic [1:0][5:0]  retire_prn_prev;
    logic [1:0]       retire_prn_prev_valid;
    logic [1:0]       retire_prn_prev_ready;
    logic [31:0][5:0] arch_rat;
    logic             recov_arch_st;
    logic             halted;
    logic [31:0]      retire_cnt;

    int checks   = 0;
    int failures = 0;

    retire_commit dut (
        .clk                    (clk),
        .rst                    (rst),
        .rob_head_valid         (rob_head_valid),
        .rob_head_dest_arn      (rob_head_dest_arn),
        .rob_head_dest_prn      (rob_head_dest_prn),
        .rob_head_dest_prn_prev (rob_head_dest_prn_prev),
        .rob_head_has_dest      (rob_head_has_dest),
        .rob_head_mispredict    (rob_head_mispredict),
        .rob_head_halt          (rob_head_halt),
        .rob_retire             (rob_retire),
        .retire_prn_prev        (retire_prn_prev),
        .retire_prn_prev_valid  (retire_prn_prev_valid),
        .retire_prn_prev_ready  (retire_prn_prev_ready),
        .arch_rat               (arch_rat),
        .recov_arch_st          (recov_arch_st),
        .halted                 (halted),
        .retire_cnt             (retire_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rob_head_valid         = '0;
        rob_head_dest_arn      = '0;
        rob_head_dest_prn      = '0;
        rob_head_dest_prn_prev = '0;
        rob_head_has_dest      = '0;
        rob_head_mispredict    = '0;
        rob_head_halt          = '0;
        retire_prn_prev_ready  = '0;
    endtask

    task automatic set_slot(input int s, input logic [4:0] arn, input logic [5:0] prn,
                            input logic [5:0] prev, input logic hd);
        rob_head_valid[s]         = 1'b1;
        rob_head_dest_arn[s]      = arn;
        rob_head_dest_prn[s]      = prn;
        rob_head_dest_prn_prev[s] = prev;
        rob_head_has_dest[s]      = hd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        set_slot(0, 5'd1, 6'd60, 6'd1, 1'b1);
        set_slot(1, 5'd2, 6'd61, 6'd2, 1'b1);
        retire_prn_prev_ready = 2'b11;
        tick(); tick();
        checks++; if (rob_retire !== 2'b00) begin failures++;
            $display("FAIL reset_retire_in_rst got=%b exp=00", rob_retire); end
        checks++; if (retire_prn_prev_valid !== 2'b00) begin failures++;
            $display("FAIL reset_prev_valid_in_rst got=%b exp=00", retire_prn_prev_valid); end
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++; if (arch_rat[5] !== 6'd5) begin failures++;
            $display("FAIL reset_rat5 got=%0d exp=5", arch_rat[5]); end
        checks++; if (rob_retire !== 2'b00) begin failures++;
            $display("FAIL reset_retire got=%b exp=00", rob_retire); end
        checks++; if (recov_arch_st !== 1'b0 || halted !== 1'b0) begin failures++;
            $display("FAIL reset_flags got=%b%b exp=00", recov_arch_st, halted); end
        checks++; if (retire_cnt !== 32'd0) begin failures++;
            $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
    endtask

    task automatic test_dual_retire();
        clear_inputs();
        set_slot(0, 5'd3, 6'd40, 6'd3, 1'b1);
        set_slot(1, 5'd7, 6'd41, 6'd7, 1'b1);
        retire_prn_prev_ready = 2'b11;
        #1;
        checks++; if (rob_retire !== 2'b11) begin failures++;
            $display("FAIL dual_retire got=%b exp=11", rob_retire); end
        checks++; if (retire_prn_prev_valid !== 2'b11 || retire_prn_prev[0] !== 6'd3 ||
                      retire_prn_prev[1] !== 6'd7) begin failures++;
            $display("FAIL dual_prev got=%b/%0d/%0d exp=11/3/7", retire_prn_prev_valid,
                     retire_prn_prev[0], retire_prn_prev[1]); end
        tick();
        clear_inputs();
        checks++; if (arch_rat[3] !== 6'd40 || arch_rat[7] !== 6'd41) begin failures++;
            $display("FAIL dual_rat got=%0d/%0d exp=40/41", arch_rat[3], arch_rat[7]); end
        checks++; if (retire_cnt !== 32'd2) begin failures++;
            $display("FAIL dual_cnt got=%0d exp=2", retire_cnt); end
    endtask

    task automatic test_collision();
        clear_inputs();
        set_slot(0, 5'd4, 6'd50, 6'd4, 1'b1);
        set_slot(1, 5'd4, 6'd51, 6'd50, 1'b1);
        retire_prn_prev_ready = 2'b11;
        #1;
        checks++; if (rob_retire !== 2'b11 || retire_prn_prev[0] !== 6'd4 ||
                      retire_prn_prev[1] !== 6'd50) begin failures++;
            $display("FAIL coll_offer got=%b/%0d/%0d exp=11/4/50", rob_retire,
                     retire_prn_prev[0], retire_prn_prev[1]); end
        tick();
        clear_inputs();
        checks++; if (arch_rat[4] !== 6'd51) begin failures++;
            $display("FAIL coll_rat4 got=%0d exp=51", arch_rat[4]); end
        checks++; if (retire_cnt !== 32'd4) begin failures++;
            $display("FAIL coll_cnt got=%0d exp=4", retire_cnt); end
    endtask

    task automatic test_backpressure();
        clear_inputs();
        set_slot(0, 5'd6, 6'd45, 6'd6, 1'b1);
        set_slot(1, 5'd8, 6'd46, 6'd8, 1'b1);
        retire_prn_prev_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rob_retire !== 2'b00 || retire_prn_prev_valid !== 2'b01 ||
                          retire_prn_prev[0] !== 6'd6) begin failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%b/%0d exp=00/01/6", c, rob_retire,
                         retire_prn_prev_valid, retire_prn_prev[0]); end
            tick();
        end
        checks++; if (retire_cnt !== 32'd4 || arch_rat[6] !== 6'd6) begin failures++;
            $display("FAIL bp_stalled got=%0d/%0d exp=4/6", retire_cnt, arch_rat[6]); end
        retire_prn_prev_ready = 2'b11;
        #1;
        checks++; if (rob_retire !== 2'b11) begin failures++;
            $display("FAIL bp_release got=%b exp=11", rob_retire); end
        tick();
        clear_inputs();
        tick();
        checks++; if (retire_cnt !== 32'd6 || arch_rat[6] !== 6'd45 ||
                      arch_rat[8] !== 6'd46) begin failures++;
            $display("FAIL bp_once got=%0d/%0d/%0d exp=6/45/46", retire_cnt,
                     arch_rat[6], arch_rat[8]); end
    endtask

    task automatic test_no_dest();
        clear_inputs();
        set_slot(0, 5'd0, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (rob_retire !== 2'b01 || retire_prn_prev_valid !== 2'b00) begin
            failures++;
            $display("FAIL nodest got=%b/%b exp=01/00", rob_retire, retire_prn_prev_valid); end
        tick();
        clear_inputs();
        checks++; if (retire_cnt !== 32'd7 || arch_rat[0] !== 6'd0) begin failures++;
            $display("FAIL nodest_cnt got=%0d/%0d exp=7/0", retire_cnt, arch_rat[0]); end
    endtask

    task automatic test_mispredict();
        clear_inputs();
        set_slot(0, 5'd2, 6'd33, 6'd2, 1'b1);
        set_slot(1, 5'd9, 6'd34, 6'd9, 1'b1);
        rob_head_mispredict[0] = 1'b1;
        retire_prn_prev_ready  = 2'b11;
        #1;
        checks++; if (rob_retire !== 2'b01) begin failures++;
            $display("FAIL mp_retire got=%b exp=01", rob_retire); end
        tick();
        checks++; if (recov_arch_st !== 1'b1 || arch_rat[2] !== 6'd33) begin failures++;
            $display("FAIL mp_recov got=%b/%0d exp=1/33", recov_arch_st, arch_rat[2]); end
        checks++; if (rob_retire !== 2'b00 || arch_rat[9] !== 6'd9 ||
                      retire_cnt !== 32'd8) begin failures++;
            $display("FAIL mp_stall got=%b/%0d/%0d exp=00/9/8", rob_retire, arch_rat[9],
                     retire_cnt); end
        tick();
        clear_inputs();
        set_slot(0, 5'd0, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (recov_arch_st !== 1'b0 || rob_retire !== 2'b01) begin failures++;
            $display("FAIL mp_back_run got=%b/%b exp=0/01", recov_arch_st, rob_retire); end
        tick();
        clear_inputs();
        checks++; if (retire_cnt !== 32'd9 || arch_rat[9] !== 6'd9) begin failures++;
            $display("FAIL mp_cnt got=%0d/%0d exp=9/9", retire_cnt, arch_rat[9]); end
    endtask

    task automatic test_halt_reset();
        clear_inputs();
        set_slot(0, 5'd0, 6'd0, 6'd0, 1'b0);
        set_slot(1, 5'd0, 6'd0, 6'd0, 1'b0);
        rob_head_halt[1] = 1'b1;
        #1;
        checks++; if (rob_retire !== 2'b11) begin failures++;
            $display("FAIL halt_retire got=%b exp=11", rob_retire); end
        tick();
        rob_head_halt = '0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (halted !== 1'b1 || rob_retire !== 2'b00) begin failures++;
                $display("FAIL halt_hold cyc=%0d got=%b/%b exp=1/00", c, halted, rob_retire); end
            tick();
        end
        checks++; if (retire_cnt !== 32'd11) begin failures++;
            $display("FAIL halt_cnt got=%0d exp=11", retire_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        set_slot(0, 5'd0, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (halted !== 1'b0 || arch_rat[3] !== 6'd3 || arch_rat[4] !== 6'd4 ||
                      retire_cnt !== 32'd0) begin failures++;
            $display("FAIL halt_rst got=%b/%0d/%0d/%0d exp=0/3/4/0", halted, arch_rat[3],
                     arch_rat[4], retire_cnt); end
        checks++; if (rob_retire !== 2'b01) begin failures++;
            $display("FAIL halt_rst_run got=%b exp=01", rob_retire); end
        clear_inputs();
    endtask

    task automatic test_halt_beats_mispredict();
        clear_inputs();
        set_slot(0, 5'd0, 6'd0, 6'd0, 1'b0);
        set_slot(1, 5'd0, 6'd0, 6'd0, 1'b0);
        rob_head_halt[0]       = 1'b1;
        rob_head_mispredict[0] = 1'b1;
        #1;
        checks++; if (rob_retire !== 2'b01) begin failures++;
            $display("FAIL hm_retire got=%b exp=01", rob_retire); end
        tick();
        checks++; if (halted !== 1'b1 || recov_arch_st !== 1'b0) begin failures++;
            $display("FAIL hm_state got=%b/%b exp=1/0", halted, recov_arch_st); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_dual_retire();
        test_collision();
        test_backpressure();
        test_no_dest();
        test_mispredict();
        test_halt_reset();
        test_halt_beats_mispredict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
